hwag_ign_sched: RTL and testbench
=================================

// Module: hwag_ign_sched
// PURPOSE
// Multi-channel angle-domain output scheduler; parametrised successor of the single ignition comparator on ACNT2.
// Each channel drives its output high from a programmed start angle to an end angle of the angle counter.
// Windows may wrap through zero. Programming is double-buffered and applied at the gap point.
// Sits behind the angle counter; per-channel registers are written through the ssram bus decode.
// PARAMETERS
// CH    4     number of output channels (1..16)
// AW    24    angle counter / angle register width
// DW    24    dwell-limit counter width (used only with HWAG_IGN_DWELL_LIMIT_EN)
// PORTS
// clk        in   1          system clock
// rst        in   1          asynchronous, active-low reset
// sync       in   1          engine synchronised (hwag_start); 0 forces all channels idle
// acnt       in   AW         current angle count
// acnt_stb   in   1          one-clk strobe: acnt advanced this cycle
// upd_stb    in   1          one-clk strobe at gap point: shadow -> active copy
// wr_en      in   1          shadow write strobe
// wr_ch      in   $clog2(CH) channel selected for the write
// wr_sel     in   2          0=start angle, 1=end angle, 2=enable bit (wr_data[0]), 3=dwell max
// wr_data    in   AW         write data; bits above the field width are ignored
// ch_out     out  CH         channel outputs
// ch_act     out  CH         active-copy enable bit of each channel
// ch_flt     out  CH         sticky dwell fault; cleared by a write of the enable bit
// BEHAVIOUR
// - Reset: all shadow/active registers 0, FSMs IDLE, ch_out=0, ch_act=0, ch_flt=0.
// - Shadow write: takes effect on the clk edge with wr_en=1; wr_ch>=CH is ignored.
// - Update: on upd_stb, every channel copies shadow -> active.
// - Write and update in the same cycle: the active copy takes the pre-write shadow; the new value waits for the next upd_stb.
// - Per-channel FSM, evaluated only on cycles with acnt_stb=1, except where noted:
//   IDLE: entered from reset, on sync=0, or with active enable=0.
//     -> ARMED when sync=1, enable=1 and start!=end.
//   ARMED: acnt==start -> ON.
//   ON: acnt==end -> ARMED.
//     sync=0 or enable cleared by an update -> IDLE immediately, without waiting for acnt_stb.
// - ch_out is registered: 1 exactly while FSM=ON.
//   It rises the clk after the acnt_stb cycle where acnt==start, and falls the clk after acnt==end.
// - Wrap: start>end is legal. The output stays on through acnt rollover (e.g. start=F0, end=10) with no special case.
// - start==end: the channel never leaves IDLE and the output stays 0.
// - Update while ON: the new end angle applies immediately. If the new window no longer contains acnt, the output stays on until acnt==new end.
// - Only equality compares are used. acnt_stb must step by 1 with no reload inside a window.
// - Channels are independent; overlapping windows on different channels are legal.
// - A dropped sync clears outputs combinationally-free: registered, 1 clk latency.
// CONFIGURATION
// - HWAG_IGN_DWELL_LIMIT_EN defined:
//   - Per-channel DW-bit clk counter: reset on entry to ON, incremented every clk while ON.
//   - If the count reaches the channel's active dwell max (nonzero), the output is forced 0, FSM -> ARMED, and ch_flt sets.
//   - A dwell max of 0 disables the limit.
// - HWAG_IGN_DWELL_LIMIT_EN undefined:
//   - No counters; wr_sel=3 writes are discarded.
//   - ch_flt is tied to 0 and the ON state exits only on the end angle or sync loss.
// TESTING
// 1. CH=4. ch0 start=10, end=20, enable=1, then upd_stb; sync=1; step acnt 0..FF ->
//    ch_out[0] high from the clk after acnt=10 to the clk after acnt=20 (10 strobes); other channels stay 0.
// 2. ch1 start=F0, end=10; step acnt E0..FF, 0..20 -> ch_out[1] high from F0 through rollover, low after acnt=10.
// 3. In a running ch0 window, write end=30 with no upd_stb -> still falls at 20; after upd_stb, next revolution falls at 30.
// 4. wr_en and upd_stb in the same cycle writing start=40 over old 10 -> this revolution fires at 10, the next at 40.
// 5. sync dropped while ch0 is ON (acnt=15) -> ch_out[0]=0 on the next clk; no re-fire until sync=1 and acnt=10 again.
// 6. With HWAG_IGN_DWELL_LIMIT_EN: dwell max=8, hold acnt_stb=0 inside the window -> output off 8 clks after rising, ch_flt[0]=1.
//    Writing enable=1 clears ch_flt[0]. Without the macro the output stays high.

Source files
------------

// File: rtl/hwag_ign_sched_if.sv
// Shadow-register write port of hwag_ign_sched, driven by the ssram bus decode.
interface hwag_ign_sched_if #(
  parameter int unsigned CH = 4,
  parameter int unsigned AW = 24
);
  localparam int unsigned CHW = (CH > 1) ? $clog2(CH) : 1;

  logic           wr_en;
  logic [CHW-1:0] wr_ch;
  logic [1:0]     wr_sel;
  logic [AW-1:0]  wr_data;

  modport master (output wr_en, wr_ch, wr_sel, wr_data);
  modport slave  (input  wr_en, wr_ch, wr_sel, wr_data);
endinterface

// File: rtl/hwag_ign_sched.sv
// Multi-channel angle-window output scheduler with double-buffered programming.
// Optional per-channel dwell limit enabled by defining HWAG_IGN_DWELL_LIMIT_EN.
module hwag_ign_sched #(
  parameter int unsigned CH = 4,
  parameter int unsigned AW = 24,
  parameter int unsigned DW = 24
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            sync,
  input  logic [AW-1:0]   acnt,
  input  logic            acnt_stb,
  input  logic            upd_stb,
  hwag_ign_sched_if.slave bus,
  output logic [CH-1:0]   ch_out,
  output logic [CH-1:0]   ch_act,
  output logic [CH-1:0]   ch_flt
);
  localparam int unsigned CHW = (CH > 1) ? $clog2(CH) : 1;

  typedef enum logic [1:0] {S_IDLE, S_ARMED, S_ON} state_t;

  logic [AW-1:0] sh_start  [CH];
  logic [AW-1:0] sh_end    [CH];
  logic [AW-1:0] act_start [CH];
  logic [AW-1:0] act_end   [CH];
  logic [CH-1:0] sh_en;
  logic [CH-1:0] act_en;
  logic [CH-1:0] wr_hit;
  state_t        state     [CH];
  state_t        state_nx  [CH];

`ifdef HWAG_IGN_DWELL_LIMIT_EN
  logic [DW-1:0] sh_dmax  [CH];
  logic [DW-1:0] act_dmax [CH];
  logic [DW-1:0] dcnt     [CH];
  logic [CH-1:0] dwell_hit;
  logic [CH-1:0] trip;
  logic [CH-1:0] flt;
`endif

  // Out-of-range channel numbers never match, so those writes fall away.
  always_comb begin
    for (int unsigned i = 0; i < CH; i++)
      wr_hit[i] = bus.wr_en && (bus.wr_ch == CHW'(i));
  end

  // Update reads the shadow before this edge's write lands.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < CH; i++) begin
        sh_start[i]  <= '0;
        sh_end[i]    <= '0;
        act_start[i] <= '0;
        act_end[i]   <= '0;
      end
      sh_en  <= '0;
      act_en <= '0;
    end else begin
      for (int unsigned i = 0; i < CH; i++) begin
        if (upd_stb) begin
          act_start[i] <= sh_start[i];
          act_end[i]   <= sh_end[i];
          act_en[i]    <= sh_en[i];
        end
        if (wr_hit[i]) begin
          case (bus.wr_sel)
            2'd0:    sh_start[i] <= bus.wr_data;
            2'd1:    sh_end[i]   <= bus.wr_data;
            2'd2:    sh_en[i]    <= bus.wr_data[0];
            default: ;
          endcase
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < CH; i++)
        state[i] <= S_IDLE;
    end else begin
      for (int unsigned i = 0; i < CH; i++)
        state[i] <= state_nx[i];
    end
  end

  // Loss of sync, a disabled channel or an empty window park the channel
  // in IDLE on any clock; angle-driven moves wait for acnt_stb.
  always_comb begin
    for (int unsigned i = 0; i < CH; i++) begin
      state_nx[i] = state[i];
`ifdef HWAG_IGN_DWELL_LIMIT_EN
      trip[i] = 1'b0;
`endif
      if (!sync || !act_en[i] || (act_start[i] == act_end[i])) begin
        state_nx[i] = S_IDLE;
      end else begin
        case (state[i])
          S_IDLE:  if (acnt_stb) state_nx[i] = S_ARMED;
          S_ARMED: if (acnt_stb && (acnt == act_start[i])) state_nx[i] = S_ON;
          S_ON: begin
            if (acnt_stb && (acnt == act_end[i])) begin
              state_nx[i] = S_ARMED;
            end
`ifdef HWAG_IGN_DWELL_LIMIT_EN
            else if (dwell_hit[i]) begin
              state_nx[i] = S_ARMED;
              trip[i]     = 1'b1;
            end
`endif
          end
          default: state_nx[i] = S_IDLE;
        endcase
      end
    end
  end

`ifdef HWAG_IGN_DWELL_LIMIT_EN
  // dcnt holds the number of clocks the output has been high, so a limit
  // of N trips on the edge that would start the (N+1)th high clock.
  always_comb begin
    for (int unsigned i = 0; i < CH; i++)
      dwell_hit[i] = (state[i] == S_ON) && (act_dmax[i] != '0) && (dcnt[i] == act_dmax[i]);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < CH; i++) begin
        sh_dmax[i]  <= '0;
        act_dmax[i] <= '0;
        dcnt[i]     <= '0;
      end
      flt <= '0;
    end else begin
      for (int unsigned i = 0; i < CH; i++) begin
        if (upd_stb)
          act_dmax[i] <= sh_dmax[i];
        if (wr_hit[i] && (bus.wr_sel == 2'd3))
          sh_dmax[i] <= DW'(bus.wr_data);
        if ((state_nx[i] == S_ON) && (state[i] != S_ON))
          dcnt[i] <= DW'(1);
        else if (state[i] == S_ON)
          dcnt[i] <= dcnt[i] + DW'(1);
        if (wr_hit[i] && (bus.wr_sel == 2'd2))
          flt[i] <= 1'b0;
        if (trip[i])
          flt[i] <= 1'b1;
      end
    end
  end
`endif

  always_comb begin
    for (int unsigned i = 0; i < CH; i++)
      ch_out[i] = (state[i] == S_ON);
    ch_act = act_en;
`ifdef HWAG_IGN_DWELL_LIMIT_EN
    ch_flt = flt;
`else
    ch_flt = '0;
`endif
  end

endmodule

// File: tb/tb_hwag_ign_sched.sv
// Bench for hwag_ign_sched: directed vector table, window corner sequences,
// then random traffic against a cycle-level behavioural model.
module tb_hwag_ign_sched;
`ifdef HWAG_IGN_DWELL_LIMIT_EN
  localparam bit DWELL = 1'b1;
`else
  localparam bit DWELL = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       sync;
  logic [7:0] acnt;
  logic       acnt_stb;
  logic       upd_stb;
  logic [3:0] ch_out, ch_act, ch_flt;

  int n_chk = 0;
  int n_err = 0;

  hwag_ign_sched_if #(.CH(4), .AW(8)) bus ();

  hwag_ign_sched #(.CH(4), .AW(8), .DW(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .sync     (sync),
    .acnt     (acnt),
    .acnt_stb (acnt_stb),
    .upd_stb  (upd_stb),
    .bus      (bus),
    .ch_out   (ch_out),
    .ch_act   (ch_act),
    .ch_flt   (ch_flt)
  );

  always #5 clk = ~clk;

  // Behavioural model: per channel, "live" means it has left idle, "on" is the output.
  logic [7:0] m_sh_start[4], m_sh_end[4], m_act_start[4], m_act_end[4];
  logic [7:0] m_sh_dmax[4], m_act_dmax[4];
  logic [3:0] m_sh_en, m_act_en, m_on, m_live, m_flt;
  int         m_hi[4];

  typedef struct {
    logic [7:0] a;
    logic       s;
    logic [3:0] exp;
  } vec_t;
  vec_t tv[$];

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
    end
  endtask

  task automatic model_step();
    logic [3:0] on_n, live_n, trip;
    int c;
    on_n = m_on; live_n = m_live; trip = '0;
    for (int k = 0; k < 4; k++) begin
      if (!sync || !m_act_en[k] || (m_act_start[k] == m_act_end[k])) begin
        on_n[k] = 1'b0; live_n[k] = 1'b0;
      end else if (m_on[k]) begin
        if (acnt_stb && acnt == m_act_end[k]) on_n[k] = 1'b0;
        else if (DWELL && m_act_dmax[k] != 8'd0 && 8'(m_hi[k]) == m_act_dmax[k]) begin
          on_n[k] = 1'b0; trip[k] = 1'b1;
        end
      end else if (m_live[k]) begin
        if (acnt_stb && acnt == m_act_start[k]) on_n[k] = 1'b1;
      end else if (acnt_stb) begin
        live_n[k] = 1'b1;
      end
      m_hi[k] = on_n[k] ? (m_on[k] ? m_hi[k] + 1 : 1) : 0;
    end
    if (upd_stb) begin
      for (int k = 0; k < 4; k++) begin
        m_act_start[k] = m_sh_start[k];
        m_act_end[k]   = m_sh_end[k];
        m_act_dmax[k]  = m_sh_dmax[k];
      end
      m_act_en = m_sh_en;
    end
    if (bus.wr_en) begin
      c = int'(bus.wr_ch);
      case (bus.wr_sel)
        2'd0: m_sh_start[c] = bus.wr_data;
        2'd1: m_sh_end[c]   = bus.wr_data;
        2'd2: begin m_sh_en[c] = bus.wr_data[0]; m_flt[c] = 1'b0; end
        default: if (DWELL) m_sh_dmax[c] = bus.wr_data;
      endcase
    end
    m_flt  = m_flt | trip;
    m_on   = on_n;
    m_live = live_n;
  endtask

  task automatic cyc();
    @(posedge clk);
    model_step();
    #1;
    chk("model_ch_out", ch_out, m_on);
    chk("model_ch_act", ch_act, m_act_en);
    chk("model_ch_flt", ch_flt, m_flt);
    bus.wr_en = 1'b0; upd_stb = 1'b0; acnt_stb = 1'b0;
  endtask

  task automatic wr(input int ch, input int sel, input logic [7:0] d);
    bus.wr_en = 1'b1; bus.wr_ch = 2'(ch); bus.wr_sel = 2'(sel); bus.wr_data = d;
    cyc();
  endtask

  task automatic upd();
    upd_stb = 1'b1;
    cyc();
  endtask

  task automatic stb(input logic [7:0] a);
    acnt = a; acnt_stb = 1'b1;
    cyc();
  endtask

  task automatic step_to(input logic [7:0] t);
    for (int n = 0; n < 300 && acnt != t; n++) stb(acnt + 8'd1);
  endtask

  initial begin
    int hi0, hi1;
    logic [7:0] a;
    rst = 1'b0; sync = 1'b0; acnt = '0; acnt_stb = 1'b0; upd_stb = 1'b0;
    bus.wr_en = 1'b0; bus.wr_ch = '0; bus.wr_sel = '0; bus.wr_data = '0;
    for (int k = 0; k < 4; k++) begin
      m_sh_start[k] = '0; m_sh_end[k] = '0; m_act_start[k] = '0; m_act_end[k] = '0;
      m_sh_dmax[k] = '0; m_act_dmax[k] = '0; m_hi[k] = 0;
    end
    m_sh_en = '0; m_act_en = '0; m_on = '0; m_live = '0; m_flt = '0;

    #12;
    chk("reset_ch_out", ch_out, 4'h0);
    chk("reset_ch_act", ch_act, 4'h0);
    chk("reset_ch_flt", ch_flt, 4'h0);
    @(negedge clk);
    rst = 1'b1;

    // ch0 10..20, ch1 F0..10 (wraps); channels 2/3 left disabled
    wr(0, 0, 8'h10); wr(0, 1, 8'h20); wr(0, 2, 8'h01);
    wr(1, 0, 8'hF0); wr(1, 1, 8'h10); wr(1, 2, 8'h01);
    chk("act_before_upd", ch_act, 4'h0);
    upd();
    chk("act_after_upd", ch_act, 4'h3);
    sync = 1'b1;
    stb(8'h00);

    tv.push_back('{a: 8'h08, s: 1'b1, exp: 4'h0});
    tv.push_back('{a: 8'h0F, s: 1'b1, exp: 4'h0});
    tv.push_back('{a: 8'h10, s: 1'b1, exp: 4'h1});
    tv.push_back('{a: 8'h11, s: 1'b1, exp: 4'h1});
    tv.push_back('{a: 8'h20, s: 1'b0, exp: 4'h1});
    tv.push_back('{a: 8'h1F, s: 1'b1, exp: 4'h1});
    tv.push_back('{a: 8'h20, s: 1'b1, exp: 4'h0});
    tv.push_back('{a: 8'h21, s: 1'b1, exp: 4'h0});
    tv.push_back('{a: 8'hEF, s: 1'b1, exp: 4'h0});
    tv.push_back('{a: 8'hF0, s: 1'b1, exp: 4'h2});
    tv.push_back('{a: 8'hF1, s: 1'b1, exp: 4'h2});
    tv.push_back('{a: 8'hFF, s: 1'b1, exp: 4'h2});
    tv.push_back('{a: 8'h00, s: 1'b1, exp: 4'h2});
    tv.push_back('{a: 8'h0F, s: 1'b1, exp: 4'h2});
    tv.push_back('{a: 8'h10, s: 1'b1, exp: 4'h1});
    tv.push_back('{a: 8'h11, s: 1'b1, exp: 4'h1});
    tv.push_back('{a: 8'h20, s: 1'b1, exp: 4'h0});
    foreach (tv[i]) begin
      acnt = tv[i].a; acnt_stb = tv[i].s;
      cyc();
      chk($sformatf("vec%0d", i), ch_out, tv[i].exp);
    end

    // one full revolution: each window spans 0x10 and 0x20 strobes
    hi0 = 0; hi1 = 0;
    for (int n = 0; n < 256; n++) begin
      stb(acnt + 8'd1);
      hi0 += int'(ch_out[0]);
      hi1 += int'(ch_out[1]);
    end
    chk("rev_hi_ch0", hi0, 16);
    chk("rev_hi_ch1", hi1, 32);

    // shadow end write without update leaves the running window alone
    step_to(8'h15);
    chk("t3_on", ch_out[0], 1'b1);
    wr(0, 1, 8'h30);
    step_to(8'h1F);
    chk("t3_on_1f", ch_out[0], 1'b1);
    step_to(8'h20);
    chk("t3_off_20", ch_out[0], 1'b0);
    step_to(8'h80);
    upd();
    step_to(8'h10);
    chk("t3_rise", ch_out[0], 1'b1);
    step_to(8'h2F);
    chk("t3_on_2f", ch_out[0], 1'b1);
    step_to(8'h30);
    chk("t3_off_30", ch_out[0], 1'b0);

    // write and update together: active copy takes the old start
    step_to(8'h90);
    bus.wr_en = 1'b1; bus.wr_ch = 2'd0; bus.wr_sel = 2'd0; bus.wr_data = 8'h40; upd_stb = 1'b1;
    cyc();
    step_to(8'h10);
    chk("t4_old_start", ch_out[0], 1'b1);
    step_to(8'h30);
    chk("t4_old_end", ch_out[0], 1'b0);
    upd();
    step_to(8'h3F);
    chk("t4_pre_new", ch_out[0], 1'b0);
    step_to(8'h40);
    chk("t4_new_start", ch_out[0], 1'b1);
    step_to(8'h2F);
    chk("t4_wrapped", ch_out[0], 1'b1);
    step_to(8'h30);
    chk("t4_new_end", ch_out[0], 1'b0);

    // sync loss inside a window
    wr(0, 0, 8'h10);
    upd();
    step_to(8'h15);
    chk("t5_on", ch_out[0], 1'b1);
    sync = 1'b0;
    cyc();
    chk("t5_sync_drop", ch_out, 4'h0);
    sync = 1'b1;
    step_to(8'h2F);
    chk("t5_no_refire", ch_out[0], 1'b0);
    step_to(8'h0F);
    chk("t5_armed_0f", ch_out[0], 1'b0);
    step_to(8'h10);
    chk("t5_refire", ch_out[0], 1'b1);

    // dwell limit of 8 clocks with the angle held still
    step_to(8'h30);
    wr(0, 3, 8'h08);
    upd();
    step_to(8'h10);
    chk("t6_rise", ch_out[0], 1'b1);
    for (int k = 1; k < 8; k++) begin
      cyc();
      chk($sformatf("t6_hold%0d", k), ch_out[0], 1'b1);
    end
    cyc();
    chk("t6_after8", ch_out[0], DWELL ? 1'b0 : 1'b1);
    chk("t6_flt", ch_flt[0], DWELL);
    for (int k = 0; k < 12; k++) cyc();
    chk("t6_late", ch_out[0], DWELL ? 1'b0 : 1'b1);
    wr(0, 2, 8'h01);
    chk("t6_flt_clr", ch_flt[0], 1'b0);

    // random traffic against the model
    for (int n = 0; n < 6000; n++) begin
      if ($urandom_range(0, 15) == 0) begin
        bus.wr_en = 1'b1;
        bus.wr_ch = 2'($urandom_range(0, 3));
        bus.wr_sel = 2'($urandom_range(0, 3));
        if (bus.wr_sel == 2'd2) a = 8'($urandom_range(0, 3) != 0);
        else if (bus.wr_sel == 2'd3) a = 8'($urandom_range(0, 3) == 0 ? 0 : $urandom_range(1, 63));
        else a = 8'($urandom);
        bus.wr_data = a;
      end
      upd_stb = ($urandom_range(0, 31) == 0);
      sync = ($urandom_range(0, 127) != 0);
      if ($urandom_range(0, 3) != 0) begin
        acnt = acnt + 8'd1; acnt_stb = 1'b1;
      end
      cyc();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
